// File: rtl/rv32i_hazard_ctrl.sv
// rtl/rv32i_hazard_ctrl.sv - RV32I hazard, operand-forwarding and redirect-flush controller
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   id_valid/rs1/rs2/use_rs1/use_rs2/rd/we/is_load
//                                 instruction currently in decode
//   ex_redirect                   taken branch/jump resolved in EX
//   rf_a, rf_b                    register-file read data
//   stage_data                    stage k result at [k*XLEN +: XLEN] (0=EX, 1=DM, 2=WB)
//   op_a, op_b                    forwarded operands
//   fwd_sel_a, fwd_sel_b          0 = register file, k+1 = stage k
//   stall                         hold PC and IF/ID
//   kill_id                       turn decode into a bubble
//   stall_cnt, flush_cnt          saturating event counters
module rv32i_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int FWD_STAGES   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [RA_W-1:0]            id_rs1,
  input  logic [RA_W-1:0]            id_rs2,
  input  logic                       id_use_rs1,
  input  logic                       id_use_rs2,
  input  logic [RA_W-1:0]            id_rd,
  input  logic                       id_we,
  input  logic                       id_is_load,
  input  logic                       ex_redirect,
  input  logic [XLEN-1:0]            rf_a,
  input  logic [XLEN-1:0]            rf_b,
  input  logic [FWD_STAGES*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]            op_a,
  output logic [XLEN-1:0]            op_b,
  output logic [SEL_W-1:0]           fwd_sel_a,
  output logic [SEL_W-1:0]           fwd_sel_b,
  output logic                       stall,
  output logic                       kill_id,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  // Flush counter only needs to hold FLUSH_CYCLES-1; keep at least one bit.
  localparam int FL_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  logic [FWD_STAGES-1:0] t_v;
  logic [FWD_STAGES-1:0] t_we;
  logic [FWD_STAGES-1:0] t_ld;
  logic [RA_W-1:0]       t_rd [FWD_STAGES];
  logic [FL_W-1:0]       fl_ctr;

  logic [FWD_STAGES-1:0] match_a;
  logic [FWD_STAGES-1:0] match_b;
  logic [SEL_W-1:0]      sel_a_c;
  logic [SEL_W-1:0]      sel_b_c;
  logic [XLEN-1:0]       op_a_c;
  logic [XLEN-1:0]       op_b_c;
  logic                  load_use;
  logic                  kill_c;

  always_comb begin
    match_a  = '0;
    match_b  = '0;
    load_use = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      match_a[k] = t_v[k] & t_we[k] & (t_rd[k] == id_rs1) & (id_rs1 != '0) & id_use_rs1 & id_valid;
      match_b[k] = t_v[k] & t_we[k] & (t_rd[k] == id_rs2) & (id_rs2 != '0) & id_use_rs2 & id_valid;
      if ((match_a[k] | match_b[k]) & t_ld[k] & (k < LOAD_LAT))
        load_use = 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching producer is the final winner.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    op_a_c  = rf_a;
    op_b_c  = rf_b;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        sel_a_c = SEL_W'(k + 1);
        op_a_c  = stage_data[k*XLEN +: XLEN];
      end
      if (match_b[k]) begin
        sel_b_c = SEL_W'(k + 1);
        op_b_c  = stage_data[k*XLEN +: XLEN];
      end
    end
  end

  assign kill_c = ex_redirect | (fl_ctr != '0);

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    kill_id   = ~reset & kill_c;
    stall     = ~reset & ~kill_c & load_use;
    fwd_sel_a = reset ? '0 : sel_a_c;
    fwd_sel_b = reset ? '0 : sel_b_c;
    op_a      = reset ? rf_a : op_a_c;
    op_b      = reset ? rf_b : op_b_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_v       <= '0;
      fl_ctr    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = FWD_STAGES - 1; k > 0; k--) begin
        t_v[k]  <= t_v[k-1];
        t_we[k] <= t_we[k-1];
        t_ld[k] <= t_ld[k-1];
        t_rd[k] <= t_rd[k-1];
      end
      // A stalled or killed decode slot enters EX as a bubble.
      t_v[0]  <= id_valid & ~stall & ~kill_id;
      t_we[0] <= id_we;
      t_ld[0] <= id_is_load;
      t_rd[0] <= id_rd;

      if (ex_redirect)
        fl_ctr <= FL_W'(FLUSH_CYCLES - 1);
      else if (fl_ctr != '0)
        fl_ctr <= fl_ctr - FL_W'(1);

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (kill_id && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// tb/tb_rv32i_hazard_ctrl.sv - directed self-checking bench for rv32i_hazard_ctrl
module tb_rv32i_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, ex_redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] rf_a, rf_b;
  logic [95:0] stage_data;
  logic [31:0] op_a, op_b, op_a4, op_b4;
  logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_a4, fwd_sel_b4;
  logic        stall, kill_id, stall4, kill_id4;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .rf_a(rf_a), .rf_b(rf_b),
    .stage_data(stage_data), .op_a(op_a), .op_b(op_b), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .stall(stall), .kill_id(kill_id), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  rv32i_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .rf_a(rf_a), .rf_b(rf_b),
    .stage_data(stage_data), .op_a(op_a4), .op_b(op_b4), .fwd_sel_a(fwd_sel_a4),
    .fwd_sel_b(fwd_sel_b4), .stall(stall4), .kill_id(kill_id4), .stall_cnt(stall_cnt4),
    .flush_cnt(flush_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_we = we; id_is_load = ld;
  endtask

  initial begin
    reset = 1'b1;
    ex_redirect = 1'b0;
    rf_a = 32'h0000_AAAA;
    rf_b = 32'h0000_BBBB;
    stage_data = {32'h0000_9ABC, 32'h0000_5678, 32'h0000_1234};
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset held, redirect asserted: outputs must stay idle.
    ex_redirect = 1'b1;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("rst_kill", {31'b0, kill_id}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_sel_a", {30'b0, fwd_sel_a}, 32'd0);
    chk("rst_op_b", op_b, 32'h0000_BBBB);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    ex_redirect = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("post_rst_kill", {31'b0, kill_id}, 32'd0);

    // EX->EX forward: add x5, then consumer of x5.
    set_id(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("ex_fwd_sel_a", {30'b0, fwd_sel_a}, 32'd1);
    chk("ex_fwd_op_a", op_a, 32'h0000_1234);
    chk("ex_fwd_stall", {31'b0, stall}, 32'd0);
    chk("no_fwd_sel_b", {30'b0, fwd_sel_b}, 32'd0);
    tick();

    // Load-use: lw x6, consumer stalls one cycle, then forwards from DM.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    settle();
    chk("lu_release", {31'b0, stall}, 32'd0);
    chk("lu_sel_b", {30'b0, fwd_sel_b}, 32'd2);
    chk("lu_op_b", op_b, 32'h0000_5678);
    chk("lu_stall_cnt", {16'b0, stall_cnt}, 32'd1);
    tick();

    // Priority: x7 producers in EX and WB; youngest (EX) wins.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0);
    settle();
    chk("prio_sel_a", {30'b0, fwd_sel_a}, 32'd1);
    chk("prio_op_a", op_a, 32'h0000_1234);
    chk("prio_sel_b", {30'b0, fwd_sel_b}, 32'd1);
    tick();
    // x0 never forwards, even from an entry with rd=x0, we=1.
    set_id(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("x0_sel_a", {30'b0, fwd_sel_a}, 32'd0);
    chk("x0_op_a", op_a, 32'h0000_AAAA);
    chk("dm_sel_b", {30'b0, fwd_sel_b}, 32'd2);
    chk("dm_op_b", op_b, 32'h0000_5678);
    tick();
    // No forwarding without a valid decode instruction.
    set_id(1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("inv_sel_b", {30'b0, fwd_sel_b}, 32'd0);
    chk("inv_op_b", op_b, 32'h0000_BBBB);
    tick();

    // Redirect pulse: two killed slots.
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    settle();
    chk("rd1_kill_c1", {31'b0, kill_id}, 32'd1);
    tick();
    ex_redirect = 1'b0;
    settle();
    chk("rd1_kill_c2", {31'b0, kill_id}, 32'd1);
    tick();
    settle();
    chk("rd1_kill_c3", {31'b0, kill_id}, 32'd0);
    chk("rd1_flush_cnt", {16'b0, flush_cnt}, 32'd2);
    tick();
    // Second redirect in the second killed cycle extends by one.
    ex_redirect = 1'b1;
    tick();
    settle();
    chk("rd2_kill_c2", {31'b0, kill_id}, 32'd1);
    tick();
    ex_redirect = 1'b0;
    settle();
    chk("rd2_kill_c3", {31'b0, kill_id}, 32'd1);
    tick();
    settle();
    chk("rd2_kill_c4", {31'b0, kill_id}, 32'd0);
    chk("rd2_flush_cnt", {16'b0, flush_cnt}, 32'd5);

    // Redirect coincident with load-use: kill wins, no stall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    ex_redirect = 1'b1;
    settle();
    chk("co_kill", {31'b0, kill_id}, 32'd1);
    chk("co_stall", {31'b0, stall}, 32'd0);
    tick();
    ex_redirect = 1'b0;
    set_id(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    chk("co_stall_cnt", {16'b0, stall_cnt}, 32'd1);
    chk("co_bubble_sel_b", {30'b0, fwd_sel_b}, 32'd0);
    chk("co_load_sel_a", {30'b0, fwd_sel_a}, 32'd2);
    chk("co_flush_cnt", {16'b0, flush_cnt}, 32'd6);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("co_end_kill", {31'b0, kill_id}, 32'd0);
    chk("co_end_flush_cnt", {16'b0, flush_cnt}, 32'd7);

    // Reset during a load-use stall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    chk("rs_stall_pre", {31'b0, stall}, 32'd1);
    reset = 1'b1;
    settle();
    chk("rs_stall_held", {31'b0, stall}, 32'd0);
    chk("rs_sel_a_held", {30'b0, fwd_sel_a}, 32'd0);
    chk("rs_op_a_held", op_a, 32'h0000_AAAA);
    tick();
    reset = 1'b0;
    settle();
    chk("rs_stall_after", {31'b0, stall}, 32'd0);
    chk("rs_kill_after", {31'b0, kill_id}, 32'd0);
    chk("rs_sel_a_after", {30'b0, fwd_sel_a}, 32'd0);
    chk("rs_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rs_flush_cnt", {16'b0, flush_cnt}, 32'd0);

    // Reset mid-flush leaves no residual kill.
    ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    reset = 1'b1;
    settle();
    chk("rf_kill_held", {31'b0, kill_id}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("rf_kill_after", {31'b0, kill_id}, 32'd0);
    chk("rf_flush_cnt", {16'b0, flush_cnt}, 32'd0);

    // Saturation: 20 killed cycles; 4-bit counter holds at 15.
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_redirect = 1'b1;
    repeat (20) tick();
    chk("sat_flush_cnt16", {16'b0, flush_cnt}, 32'd20);
    chk("sat_flush_cnt4", {28'b0, flush_cnt4}, 32'd15);
    tick();
    chk("sat_flush_cnt4_hold", {28'b0, flush_cnt4}, 32'd15);
    ex_redirect = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_ctrl.md
Name: rv32i_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the RV32I in-order pipeline.
- Tracks destination registers of in-flight instructions past decode in an internal shift table.
- Generates operand-forwarding selects and forwarded operands, load-use stalls, and redirect flushes.
- Keeps saturating performance counters; sits between decode and execute, fed by the EX/DM/WB stages.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- FWD_STAGES, 3, number of tracked post-decode stages (0=EX, 1=DM, 2=WB).
- LOAD_LAT, 1, a load in stage k is forwardable only when k >= LOAD_LAT.
- FLUSH_CYCLES, 2, decode slots killed per redirect (>=1).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  a real instruction is in decode.
- id_rs1, id_rs2  in  RA_W  decode source registers.
- id_use_rs1, id_use_rs2  in  1  instruction reads that source.
- id_rd  in  RA_W  decode destination register.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- rf_a, rf_b  in  XLEN  register-file read data.
- stage_data  in  FWD_STAGES*XLEN  result of stage k at bits [k*XLEN +: XLEN].
- op_a, op_b  out  XLEN  forwarded operands.
- fwd_sel_a, fwd_sel_b  out  $clog2(FWD_STAGES+1)  0 = register file, k+1 = stage k.
- stall  out  1  hold PC and IF/ID register.
- kill_id  out  1  convert decode instruction to a bubble / flush IF/ID.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Table: FWD_STAGES entries {v, rd, we, ld}. Entry 0 is EX. Every cycle, entry k+1 <= entry k, and entry 0 <= the decode instruction.
  - Entry 0 loads {id_valid, id_rd, id_we, id_is_load} when stall=0 and kill_id=0.
  - Otherwise entry 0 loads a bubble (v=0).
- Match at stage k for source rs: v & we & (rd==rs) & (rs!=0) & use_rs & id_valid.
- Forwarding:
  - fwd_sel = (lowest matching k) + 1, so the youngest producer wins; 0 if no match.
  - op = stage_data slice k, or rf data when fwd_sel=0.
  - Combinational, zero latency.
- Load-use:
  - stall=1 when a match exists at stage k with ld=1 and k < LOAD_LAT, and kill_id=0.
  - Fwd selects and ops during a stall are don't-care.
  - The stall releases automatically as the load advances. With LOAD_LAT=1 this is a 1-cycle stall, after which fwd_sel=2.
- Redirect:
  - kill_id = ex_redirect | (fl_ctr != 0).
  - On ex_redirect, fl_ctr <= FLUSH_CYCLES-1; else if fl_ctr != 0, fl_ctr decrements.
  - A redirect while fl_ctr != 0 reloads the counter.
  - Redirect has priority: when kill_id=1, stall is forced to 0.
- Counters:
  - stall_cnt increments in each cycle with stall=1.
  - flush_cnt increments in each cycle with kill_id=1.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous):
  - Next edge: all entries v=0, fl_ctr=0, counters=0.
  - While reset is high, stall=0, kill_id=0, fwd_sel_a=fwd_sel_b=0, op_a=rf_a, op_b=rf_b.
  - Reset mid-stall or mid-flush abandons the stall/flush; there is no residual kill after reset deasserts.
- Width rules: rd/rs compare uses all RA_W bits. Register 0 never forwards even when an entry has rd=0 and we=1.

Test Plan:
1. Forward EX→EX: add x5 (we=1), then next cycle use rs1=x5, stage_data[0]=0x0000_1234 → fwd_sel_a=1, op_a=0x1234, stall=0.
2. Load-use: lw x6, then next cycle use rs2=x6 → stall=1 for exactly 1 cycle, stall_cnt=1. In the following cycle fwd_sel_b=2 and op_b=stage_data slice 1.
3. Priority and x0:
   - x7 written by the instructions in WB and in EX → fwd_sel=1 (youngest wins).
   - rs1=x0 with entry rd=x0, we=1 → fwd_sel_a=0, op_a=rf_a.
4. Redirect, FLUSH_CYCLES=2:
   - ex_redirect pulse → kill_id high for 2 cycles, then low; flush_cnt=2.
   - A second redirect during the 2nd cycle → kill_id extends 1 more cycle; flush_cnt=3.
5. Simultaneous redirect and load-use condition → kill_id=1, stall=0, stall_cnt unchanged, entry 0 becomes a bubble.
6. Reset during a load-use stall → after the reset edge stall=0, kill_id=0, counters=0, and all fwd_sel=0 for any sources. Counter preloaded near all-ones with CNT_W=4 saturates at 15.
